// File: rtl/i2c_eeprom_master_if.sv
// Request/response and I2C pin bundle for i2c_eeprom_master.
// master: controller side; slave: requester and bus side.
interface i2c_eeprom_master_if;
    logic       wr_req;
    logic       rd_req;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl_o;
    logic       sda_o;
    logic       sda_oe;
    logic       sda_i;

    modport master (
        input  wr_req, rd_req, reg_addr, wr_data, sda_i,
        output rd_data, busy, done, ack_err, scl_o, sda_o, sda_oe
    );

    modport slave (
        output wr_req, rd_req, reg_addr, wr_data, sda_i,
        input  rd_data, busy, done, ack_err, scl_o, sda_o, sda_oe
    );
endinterface

// File: rtl/i2c_eeprom_master.sv
// Byte-write / random-read I2C master for a 24xx-style EEPROM.
// Define I2C_EEPROM_ACK_CHECK_EN to abort on NACK and report ack_err.
module i2c_eeprom_master #(
    parameter int unsigned QTR      = 25,
    parameter logic [6:0]  DEV_ADDR = 7'b1010000
) (
    input logic                 clk,
    input logic                 reset,
    i2c_eeprom_master_if.master bus
);

`ifdef I2C_EEPROM_ACK_CHECK_EN
    localparam logic ACK_CHK = 1'b1;
`else
    localparam logic ACK_CHK = 1'b0;
`endif

    localparam logic [15:0] QTR_LAST = 16'(QTR - 1);

    typedef enum logic [3:0] {
        IDLE, START, DEV_W, ACK_DW, REG, ACK_REG, WDATA, ACK_WD,
        RSTART, DEV_R, ACK_DR, RDATA, MNACK, STOP, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] tq_q, tq_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic        op_rd_q, op_rd_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        samp_q, samp_d;
    logic        ack_err_q, ack_err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic        oe_q, oe_d;

    logic        timed;
    logic        tick;
    logic        bit_end;
    logic        nack;
    logic [7:0]  txb;

    always_comb begin
        state_d   = state_q;
        tq_d      = tq_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        op_rd_d   = op_rd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        shreg_d   = shreg_q;
        rd_data_d = rd_data_q;
        samp_d    = samp_q;
        ack_err_d = ack_err_q;

        timed   = (state_q != IDLE) && (state_q != DONE);
        tick    = timed && (tq_q == QTR_LAST);
        bit_end = tick && (qtr_q == 2'd3);
        nack    = samp_q & ACK_CHK;

        if (timed) begin
            tq_d = tick ? 16'd0 : tq_q + 16'd1;
            if (tick) qtr_d = qtr_q + 2'd1;
        end

        // SDA is sampled on the last cycle of the first SCL-high quarter
        if (tick && (qtr_q == 2'd2)) begin
            samp_d = bus.sda_i;
            if (state_q == RDATA) shreg_d = {shreg_q[6:0], bus.sda_i};
        end

        if (bit_end && (state_q inside {DEV_W, REG, WDATA, DEV_R, RDATA}))
            bit_d = bit_q + 3'd1;

        if (bit_end && nack && (state_q inside {ACK_DW, ACK_REG, ACK_WD, ACK_DR}))
            ack_err_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.wr_req || bus.rd_req) begin
                    state_d   = START;
                    op_rd_d   = ~bus.wr_req;
                    addr_d    = bus.reg_addr;
                    data_d    = bus.wr_data;
                    ack_err_d = 1'b0;
                end
            end
            START:   if (bit_end) state_d = DEV_W;
            DEV_W:   if (bit_end && bit_q == 3'd7) state_d = ACK_DW;
            ACK_DW:  if (bit_end) state_d = nack ? STOP : REG;
            REG:     if (bit_end && bit_q == 3'd7) state_d = ACK_REG;
            ACK_REG: begin
                if (bit_end)
                    state_d = nack ? STOP : (op_rd_q ? RSTART : WDATA);
            end
            WDATA:   if (bit_end && bit_q == 3'd7) state_d = ACK_WD;
            ACK_WD:  if (bit_end) state_d = STOP;
            RSTART:  if (bit_end) state_d = DEV_R;
            DEV_R:   if (bit_end && bit_q == 3'd7) state_d = ACK_DR;
            ACK_DR:  if (bit_end) state_d = nack ? STOP : RDATA;
            RDATA:   if (bit_end && bit_q == 3'd7) state_d = MNACK;
            MNACK: begin
                if (bit_end) begin
                    state_d   = STOP;
                    rd_data_d = shreg_q;
                end
            end
            STOP:    if (bit_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            DEV_W:   txb = {DEV_ADDR, 1'b0};
            DEV_R:   txb = {DEV_ADDR, 1'b1};
            REG:     txb = addr_q;
            WDATA:   txb = data_q;
            default: txb = 8'hFF;
        endcase

        // Pins are derived from the next state so they line up with it
        scl_d  = 1'b1;
        sda_d  = 1'b1;
        oe_d   = 1'b0;
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);

        unique case (state_d)
            START, RSTART: begin
                scl_d = qtr_d[1];
                sda_d = ~qtr_d[1];
                oe_d  = 1'b1;
            end
            DEV_W, DEV_R, REG, WDATA: begin
                scl_d = qtr_d[1];
                sda_d = txb[~bit_d];
                oe_d  = 1'b1;
            end
            ACK_DW, ACK_REG, ACK_WD, ACK_DR, RDATA: begin
                scl_d = qtr_d[1];
            end
            MNACK: begin
                scl_d = qtr_d[1];
                oe_d  = 1'b1;
            end
            STOP: begin
                scl_d = qtr_d[1];
                sda_d = (qtr_d == 2'd3);
                oe_d  = 1'b1;
            end
            default: begin
                scl_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tq_q      <= 16'd0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            op_rd_q   <= 1'b0;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            shreg_q   <= 8'h00;
            rd_data_q <= 8'h00;
            samp_q    <= 1'b0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tq_q      <= tq_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            op_rd_q   <= op_rd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            shreg_q   <= shreg_d;
            rd_data_q <= rd_data_d;
            samp_q    <= samp_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            oe_q      <= oe_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;
    assign bus.scl_o   = scl_q;
    assign bus.sda_o   = sda_q;
    assign bus.sda_oe  = oe_q;

endmodule

// File: tb/tb_i2c_eeprom_master.sv
// Testbench for i2c_eeprom_master: behavioural EEPROM slave, bus monitor,
// transaction-level reference model, vector table and randomized traffic.
module tb_i2c_eeprom_master;

    localparam int QTR   = 4;
    localparam int BIT   = 4 * QTR;
    localparam int EV_S  = 256;
    localparam int EV_P  = 257;
    localparam int EV_RS = -1;

`ifdef I2C_EEPROM_ACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    i2c_eeprom_master_if bif();

    i2c_eeprom_master #(
        .QTR      (QTR),
        .DEV_ADDR (7'b1010000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    bit       sl_low = 1'b0;
    int       sl_bits, sl_idx;
    bit       sl_tx, sl_first;
    bit [7:0] sl_sh;
    bit [7:0] sb;
    int       nk = -1;
    bit       prev_scl = 1'b1;
    bit       prev_ln  = 1'b1;
    int       ev_q[$];
    int       exp_q[$];
    int       exp_cyc;
    bit       exp_err;
    bit [7:0] m_rd;
    int       last_cyc;

    // Open-drain line: master drive when enabled, else slave pull-down or pull-up
    assign bif.sda_i = bif.sda_oe ? bif.sda_o : ~sl_low;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                      nm, act, act, exp, exp);
    endtask

    task automatic slave_clear();
        sl_low   = 1'b0;
        sl_bits  = 0;
        sl_idx   = 0;
        sl_tx    = 1'b0;
        sl_first = 1'b0;
        ev_q.delete();
        prev_scl = bif.scl_o;
        prev_ln  = bif.sda_i;
    endtask

    // EEPROM slave + monitor: decodes S/P and bytes from SCL/SDA edges
    initial begin
        bit scl, ln;
        forever begin
            @(negedge clk);
            scl = bif.scl_o;
            ln  = bif.sda_i;
            if (scl && (ln != prev_ln)) begin
                if (!ln) begin
                    ev_q.push_back(EV_S);
                    sl_first = 1'b1;
                end else begin
                    ev_q.push_back(EV_P);
                    sl_idx = 0;
                end
                sl_bits = 0;
                sl_tx   = 1'b0;
                sl_low  = 1'b0;
            end else if (scl && !prev_scl) begin
                if (sl_bits < 8) begin
                    sl_sh = {sl_sh[6:0], ln};
                    sl_bits++;
                    if (sl_bits == 8) ev_q.push_back(int'(sl_sh));
                end else begin
                    sl_bits = 0;
                    sl_idx++;
                    if (sl_tx) sl_tx = 1'b0;
                    else sl_tx = sl_first && sl_sh[0];
                    sl_first = 1'b0;
                end
            end else if (!scl && prev_scl) begin
                if (sl_bits == 8) sl_low = !sl_tx && (sl_idx != nk);
                else if (sl_tx) sl_low = !sb[7 - sl_bits];
                else sl_low = 1'b0;
            end
            prev_scl = scl;
            prev_ln  = ln;
        end
    end

    // Reference: expected bus events, bit count, error flag, rd_data
    task automatic model(input bit is_rd, input bit [7:0] a, input bit [7:0] d,
                         input bit [7:0] s, input int k_nack);
        int seq[$];
        int k;
        int bits;
        exp_q.delete();
        exp_err = 1'b0;
        exp_q.push_back(EV_S);
        bits = 1;
        k    = 0;
        if (is_rd) seq = {160, int'(a), EV_RS, 161, int'(s)};
        else       seq = {160, int'(a), int'(d)};
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == EV_RS) begin
                exp_q.push_back(EV_S);
                bits += 1;
            end else begin
                exp_q.push_back(seq[i]);
                bits += 9;
                if (CHK && (k == k_nack)) begin
                    exp_err = 1'b1;
                    break;
                end
                k++;
            end
        end
        exp_q.push_back(EV_P);
        bits += 1;
        exp_cyc = 1 + bits * BIT + 1;
        if (is_rd && !exp_err) m_rd = s;
    endtask

    // Entered and left on a negedge; cyc counts the accept cycle as 1
    task automatic run_txn(input bit w, input bit r, input bit [7:0] a,
                           input bit [7:0] d, input bit [7:0] s, input int k_nack);
        int cyc;
        bit got;
        model(r && !w, a, d, s, k_nack);
        sb = s;
        nk = k_nack;
        ev_q.delete();
        bif.wr_req   = w;
        bif.rd_req   = r;
        bif.reg_addr = a;
        bif.wr_data  = d;
        @(negedge clk);
        bif.wr_req   = 1'b0;
        bif.rd_req   = 1'b0;
        bif.reg_addr = 8'($urandom);
        bif.wr_data  = 8'($urandom);
        chk("busy_after_accept", int'(bif.busy), 1);
        cyc = 2;
        got = bif.done;
        while (!got && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            got = bif.done;
        end
        last_cyc = cyc;
        chk("done_seen", int'(got), 1);
        chk("latency", cyc, exp_cyc);
        chk("busy_at_done", int'(bif.busy), 0);
        chk("ack_err", int'(bif.ack_err), int'(exp_err));
        chk("rd_data", int'(bif.rd_data), int'(m_rd));
        @(negedge clk);
        chk("done_one_cycle", int'(bif.done), 0);
        chk("bus_ev_count", ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk("bus_ev", (i < ev_q.size()) ? ev_q[i] : -99, exp_q[i]);
    endtask

    typedef struct {
        bit       w;
        bit       r;
        bit [7:0] a;
        bit [7:0] d;
        bit [7:0] s;
        int       nk;
        int       e_cyc;
        bit [7:0] e_rd;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h3C, 8'hA5, 8'h00, -1, 466, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h10, 8'h00, 8'h5A, -1, 626, 8'h5A};
        tbl[2] = '{1'b1, 1'b1, 8'h77, 8'hC3, 8'hEE, -1, 466, 8'h5A};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h11, 8'hFF, -1, 626, 8'hFF};
        tbl[4] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h42, -1, 466, 8'hFF};

        reset        = 1'b1;
        bif.wr_req   = 1'b0;
        bif.rd_req   = 1'b0;
        bif.reg_addr = 8'h00;
        bif.wr_data  = 8'h00;
        sb           = 8'h00;
        m_rd         = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_scl", int'(bif.scl_o), 1);
        chk("rst_sda", int'(bif.sda_o), 1);
        chk("rst_oe", int'(bif.sda_oe), 0);
        chk("rst_busy", int'(bif.busy), 0);
        chk("rst_done", int'(bif.done), 0);
        chk("rst_ack_err", int'(bif.ack_err), 0);
        chk("rst_rd_data", int'(bif.rd_data), 0);
        slave_clear();

        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].nk);
            chk("tbl_latency", last_cyc, tbl[i].e_cyc);
            chk("tbl_rd_data", int'(bif.rd_data), int'(tbl[i].e_rd));
        end

        // NACK on register byte of a read, on data byte of a write, then clean write
        run_txn(1'b0, 1'b1, 8'h20, 8'h00, 8'h99, 1);
        run_txn(1'b1, 1'b0, 8'h21, 8'h34, 8'h00, 2);
        run_txn(1'b0, 1'b1, 8'h22, 8'h00, 8'h3E, 0);
        run_txn(1'b1, 1'b0, 8'h23, 8'h56, 8'h00, -1);

        // Reset pulse while the register byte is on the bus
        nk = -1;
        bif.wr_req   = 1'b1;
        bif.reg_addr = 8'h55;
        bif.wr_data  = 8'h66;
        @(negedge clk);
        bif.wr_req = 1'b0;
        repeat (200) @(negedge clk);
        chk("busy_in_reg", int'(bif.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_scl", int'(bif.scl_o), 1);
        chk("mid_rst_oe", int'(bif.sda_oe), 0);
        chk("mid_rst_busy", int'(bif.busy), 0);
        chk("mid_rst_done", int'(bif.done), 0);
        chk("mid_rst_rd_data", int'(bif.rd_data), 0);
        m_rd = 8'h00;
        slave_clear();
        @(negedge clk);
        run_txn(1'b1, 1'b0, 8'h55, 8'h66, 8'h00, -1);

        for (int n = 0; n < 16; n++) begin
            int       op;
            int       k;
            bit [7:0] a, d, s;
            op = int'($urandom_range(0, 2));
            k  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            a  = 8'($urandom);
            d  = 8'($urandom);
            s  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_txn(op != 1, op != 0, a, d, s, k);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_eeprom_master.md
I2C_EEPROM_MASTER -- requirements
Module: i2c_eeprom_master

Interface
REQ-001 Parameter QTR, default 25: clk cycles per SCL quarter-period; legal range 2..65535; one bit time is 4*QTR cycles.
REQ-002 Parameter DEV_ADDR, default 7'b1010000: 7-bit EEPROM device address.
REQ-003 clk  input  1  sole clock; all logic samples on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_req  input  1  byte-write request; sampled in IDLE only.
REQ-006 rd_req  input  1  random-read request; sampled in IDLE only.
REQ-007 reg_addr  input  8  EEPROM register address; captured on accept.
REQ-008 wr_data  input  8  write byte; captured on accept.
REQ-009 rd_data  output  8  byte returned by the last completed read.
REQ-010 busy  output  1  high from accept until the cycle before done.
REQ-011 done  output  1  one-cycle pulse at transaction end.
REQ-012 ack_err  output  1  valid with done; high if the transaction was aborted on a NACK.
REQ-013 scl_o  output  1  SCL drive level.
REQ-014 sda_o  output  1  SDA drive level; meaningful only when sda_oe is high.
REQ-015 sda_oe  output  1  SDA output enable; low releases the bus (tri-state at top level).
REQ-016 sda_i  input  1  sampled SDA line.

Function
REQ-017 States: IDLE, START, DEV_W, ACK_DW, REG, ACK_REG, WDATA, ACK_WD, RSTART, DEV_R, ACK_DR, RDATA, MNACK, STOP, DONE.
REQ-018 IDLE accepts a request when wr_req or rd_req is high; if both are high, the write wins and rd_req is ignored that cycle.
REQ-019 On accept, reg_addr, wr_data and the op type shall be latched, and the FSM shall enter START on the next cycle.
REQ-020 Bit timing: quarter 0 and quarter 1 hold SCL low, quarter 2 and quarter 3 hold SCL high; SDA changes only at the start of quarter 0; sda_i is sampled on the last cycle of quarter 2.
REQ-021 START/RSTART: SDA starts high and falls at the start of quarter 2 while SCL is high; the state lasts one bit time.
REQ-022 STOP: SDA is low in quarters 0 and 1 and rises at the start of quarter 3 while SCL is high.
REQ-023 Byte states shift 8 bits MSB first; a 3-bit counter counts 0..7 and wraps to 0 on exit.
REQ-024 DEV_W sends {DEV_ADDR,0}; DEV_R sends {DEV_ADDR,1}; REG sends the latched reg_addr; WDATA sends the latched wr_data.
REQ-025 ACK states: sda_oe is low for the whole bit, and the ACK is the sda_i value sampled in quarter 2 (0 = ACK).
REQ-026 Write sequence: START, DEV_W, ACK_DW, REG, ACK_REG, WDATA, ACK_WD, STOP, DONE.
REQ-027 Read sequence: START, DEV_W, ACK_DW, REG, ACK_REG, RSTART, DEV_R, ACK_DR, RDATA, MNACK, STOP, DONE.
REQ-028 RDATA: sda_oe is low, and 8 samples are shifted in MSB first. MNACK drives SDA high for one bit, then rd_data is updated.
REQ-029 DONE lasts one cycle: done=1, busy=0, and the FSM returns to IDLE. Requests are not accepted in DONE.
REQ-030 rd_data changes only at the end of a successful read and holds its value otherwise, including through write transactions.
REQ-031 Total write latency with all ACKs good is 1 + 29*4*QTR + 1 cycles, measured from the accept cycle to the done pulse.

Reset
REQ-032 On reset, including mid-transaction, the FSM goes to IDLE and all counters clear.
REQ-033 Reset values: scl_o=1, sda_o=1, sda_oe=0, busy=0, done=0, ack_err=0, rd_data=8'h00.
REQ-034 A reset asserted mid-transaction generates no STOP condition; the bus is simply released.

Configuration
REQ-035 Macro I2C_EEPROM_ACK_CHECK_EN defined: a NACK sampled in any ACK state sends the FSM straight to STOP, then DONE with ack_err=1; rd_data is unchanged.
REQ-036 I2C_EEPROM_ACK_CHECK_EN undefined: ACK values are ignored, the sequence always completes, and ack_err is tied to 0.

Verification
REQ-037 QTR=4, slave ACKs all bytes, wr_req with reg_addr=8'h3C, wr_data=8'hA5 -> bus bytes A0,3C,A5 in order, STOP seen, done after 466 cycles, ack_err=0.
REQ-038 rd_req with reg_addr=8'h10, slave returns 8'h5A -> bus shows A0,10, repeated START, A1, master NACK, STOP, and rd_data=8'h5A at done.
REQ-039 wr_req and rd_req asserted in the same cycle -> a write transaction runs (first byte A0, no repeated START), and rd_req is ignored.
REQ-040 With ACK_CHECK_EN defined, slave NACKs the register byte -> STOP follows the NACK bit, done with ack_err=1, and rd_data is unchanged.
REQ-041 reset pulsed for 1 cycle during REG -> the next cycle shows scl_o=1, sda_oe=0, busy=0, and a new wr_req then completes normally.
REQ-042 Check: SDA never changes while scl_o=1, except at START, RSTART and STOP.
